// File: rtl/qos_fifo_pkg.sv
// Shared constants and helpers for the N-class QoS buffer (qos_fifo_array).
package qos_fifo_pkg;

    localparam int unsigned NCH_DEF = 5;
    localparam int unsigned CLS_W   = $clog2(NCH_DEF);

    // Highest class a write may use: MSB set selects the top class, else qos>>1 capped below it.
    function automatic int unsigned qos_target(input logic [31:0] qos,
                                               input int unsigned qsize,
                                               input int unsigned nch);
        int unsigned t;
        if (qos[qsize-1]) begin
            return nch - 1;
        end
        t = 32'(qos >> 1);
        return (t > nch - 2) ? nch - 2 : t;
    endfunction

    // Index of the highest set bit among the low n bits (0 when none set).
    function automatic int unsigned prio_pick(input logic [31:0] mask,
                                              input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (mask[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/qos_fifo_chan.sv
// Single-clock FIFO for one QoS class; head word is presented combinationally (FWFT).
module qos_fifo_chan #(
    parameter int unsigned DSIZE = 32,
    parameter int unsigned ASIZE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [ASIZE:0]   level
);

    localparam int unsigned DEPTH = 2 ** ASIZE;
    localparam int unsigned PW    = ASIZE + 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [DSIZE-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr) wptr <= wptr + PW'(1);
            if (rd) rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[ASIZE-1:0]] <= wdata;
    end

    assign head  = mem[rptr[ASIZE-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    assign level = wptr - rptr;

endmodule

// File: rtl/qos_fifo_array.sv
// N-class QoS buffer: QoS-routed writes with upward spill, priority-arbitrated FWFT reads.
// Optional starvation aging is enabled by defining QOS_AGING_EN.
module qos_fifo_array
    import qos_fifo_pkg::*;
#(
    parameter int unsigned DSIZE      = 32,
    parameter int unsigned ASIZE      = 2,
    parameter int unsigned NCH        = 5,
    parameter int unsigned QSIZE      = 4,
    parameter int unsigned STARVE_LIM = 15
) (
    input  logic                     iClk,
    input  logic                     iResetn,
    input  logic                     iWr,
    input  logic [DSIZE-1:0]         iWrData,
    input  logic [QSIZE-1:0]         iQoS,
    output logic                     oWrReady,
    output logic                     oFull,
    input  logic                     iRd,
    output logic                     oRdValid,
    output logic [DSIZE-1:0]         oRdData,
    output logic [$clog2(NCH)-1:0]   oRdClass,
    output logic [NCH-1:0]           oEmpty,
    output logic [NCH*(ASIZE+1)-1:0] oLevel
);

    localparam int unsigned CW = $clog2(NCH);
    localparam int unsigned LW = ASIZE + 1;

    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   avail;
    logic [NCH-1:0]   wr_en;
    logic [NCH-1:0]   rd_en;
    logic [DSIZE-1:0] head  [NCH];
    logic [LW-1:0]    level [NCH];
    logic             wr_ready;
    logic             wr_go;
    logic             rd_go;
    logic             valid;
    logic             found;
    int unsigned      tgt;
    int unsigned      pick;
    logic [CW-1:0]    gnt;

    // Write router: lowest non-full class within the QoS-allowed set.
    always_comb begin
        tgt   = qos_target(32'(iQoS), QSIZE, NCH);
        avail = '0;
        wr_en = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            avail[i] = !full[i] && (iQoS[QSIZE-1] ? (i == tgt) : (i <= tgt));
        end
        wr_ready = iResetn && (|avail);
        wr_go    = iWr && wr_ready;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (avail[i] && !found) begin
                wr_en[i] = wr_go;
                found    = 1'b1;
            end
        end
    end

`ifdef QOS_AGING_EN
    localparam int unsigned AW = $clog2(STARVE_LIM + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIM);

    logic [NCH-1:0] starve;

    // Saturating wait counters: count pops lost while holding data, clear on own pop.
    for (genvar g = 0; g < NCH; g++) begin : g_age
        logic [AW-1:0] age;
        always_ff @(posedge iClk or negedge iResetn) begin
            if (!iResetn) begin
                age <= '0;
            end else if (rd_en[g]) begin
                age <= '0;
            end else if (rd_go && !empty[g] && (age != AGE_MAX)) begin
                age <= age + AW'(1);
            end
        end
        assign starve[g] = !empty[g] && (age == AGE_MAX);
    end
`endif

    // Grant arbiter: highest non-empty class, overridden by any starved class.
    always_comb begin
        valid = |(~empty);
        pick  = prio_pick(32'(~empty), NCH);
`ifdef QOS_AGING_EN
        if (|starve) pick = prio_pick(32'(starve), NCH);
`endif
        gnt   = CW'(pick);
        rd_go = iRd && valid;
        rd_en = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            rd_en[i] = rd_go && (pick == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        qos_fifo_chan #(
            .DSIZE (DSIZE),
            .ASIZE (ASIZE)
        ) u_chan (
            .clk   (iClk),
            .rst_n (iResetn),
            .wr    (wr_en[g]),
            .rd    (rd_en[g]),
            .wdata (iWrData),
            .head  (head[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .level (level[g])
        );
        assign oLevel[g*LW +: LW] = level[g];
    end

    assign oWrReady = wr_ready;
    assign oFull    = !wr_ready;
    assign oRdValid = valid;
    assign oRdData  = valid ? head[gnt] : '0;
    assign oRdClass = valid ? gnt : '0;
    assign oEmpty   = empty;

endmodule

// File: tb/tb_qos_fifo_array.sv
// Scoreboard bench for qos_fifo_array: expected pops are queued by stimulus, checked by a monitor.
module tb_qos_fifo_array;

    localparam int unsigned DSIZE = 32;
    localparam int unsigned ASIZE = 2;
    localparam int unsigned NCH   = 5;
    localparam int unsigned QSIZE = 4;
    localparam int unsigned LW    = ASIZE + 1;

    typedef struct {
        logic [2:0]  cls;
        logic [31:0] data;
    } exp_t;

    logic                 iClk;
    logic                 iResetn;
    logic                 iWr;
    logic [DSIZE-1:0]     iWrData;
    logic [QSIZE-1:0]     iQoS;
    logic                 oWrReady;
    logic                 oFull;
    logic                 iRd;
    logic                 oRdValid;
    logic [DSIZE-1:0]     oRdData;
    logic [2:0]           oRdClass;
    logic [NCH-1:0]       oEmpty;
    logic [NCH*LW-1:0]    oLevel;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    qos_fifo_array #(
        .DSIZE      (DSIZE),
        .ASIZE      (ASIZE),
        .NCH        (NCH),
        .QSIZE      (QSIZE),
        .STARVE_LIM (3)
    ) dut (
        .iClk     (iClk),
        .iResetn  (iResetn),
        .iWr      (iWr),
        .iWrData  (iWrData),
        .iQoS     (iQoS),
        .oWrReady (oWrReady),
        .oFull    (oFull),
        .iRd      (iRd),
        .oRdValid (oRdValid),
        .oRdData  (oRdData),
        .oRdClass (oRdClass),
        .oEmpty   (oEmpty),
        .oLevel   (oLevel)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] lvl(input int c);
        return oLevel[c*LW +: LW];
    endfunction

    task automatic expect_pop(input logic [2:0] c, input logic [31:0] d);
        exp_t e;
        e.cls  = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clock cycle of stimulus; returns at posedge+1 with inputs idle.
    task automatic cyc(input logic wr, input logic [3:0] qos, input logic [31:0] d, input logic rd);
        iWr     = wr;
        iQoS    = qos;
        iWrData = d;
        iRd     = rd;
        @(negedge iClk);
        @(posedge iClk);
        #1;
        iWr = 1'b0;
        iRd = 1'b0;
    endtask

    task automatic chk_ready(input string name, input logic [3:0] qos, input logic exp);
        iQoS = qos;
        #1;
        chk(name, 64'(oWrReady), 64'(exp));
        chk({name, "_full"}, 64'(oFull), 64'(!exp));
    endtask

    task automatic do_reset();
        iResetn = 1'b0;
        #2;
        @(negedge iClk);
        iResetn = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 1'b1);
    endtask

    // Monitor: every accepted pop must match the head of the expectation queue.
    always @(negedge iClk) begin
        if (iResetn && iRd && oRdValid) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'(oRdData), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pop_class", 64'(oRdClass), 64'(e.cls));
                chk("pop_data", 64'(oRdData), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        iResetn = 1'b0;
        iWr     = 1'b0;
        iRd     = 1'b0;
        iQoS    = '0;
        iWrData = '0;
        #3;
        chk("rst_ready", 64'(oWrReady), 64'h0);
        chk("rst_valid", 64'(oRdValid), 64'h0);
        chk("rst_data", 64'(oRdData), 64'h0);
        chk("rst_class", 64'(oRdClass), 64'h0);
        chk("rst_empty", 64'(oEmpty), 64'h1F);
        chk("rst_level", 64'(oLevel), 64'h0);
        do_reset();

        // T1: fill class 0, drop a write while full, drain in order
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'h0, 32'hA0 + 32'(i), 1'b0);
        chk("t1_level0", 64'(lvl(0)), 64'd4);
        chk_ready("t1_ready_q0", 4'h0, 1'b0);
        cyc(1'b1, 4'h0, 32'hA4, 1'b0);
        chk("t1_drop_level0", 64'(lvl(0)), 64'd4);
        for (int i = 0; i < 4; i++) expect_pop(3'd0, 32'hA0 + 32'(i));
        drain(4);
        chk("t1_valid_after", 64'(oRdValid), 64'h0);
        chk("t1_empty_after", 64'(oEmpty), 64'h1F);

        // T2: spill from full class 0 into class 1
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'h0, 32'hA0 + 32'(i), 1'b0);
        cyc(1'b1, 4'h3, 32'hB0, 1'b0);
        chk("t2_level1", 64'(lvl(1)), 64'd1);
        chk("t2_class", 64'(oRdClass), 64'd1);
        chk("t2_data", 64'(oRdData), 64'hB0);

        // T3: high-BW write pre-empts the presented word
        cyc(1'b1, 4'h8, 32'hC0, 1'b0);
        chk("t3_class", 64'(oRdClass), 64'd4);
        chk("t3_data", 64'(oRdData), 64'hC0);
        chk("t3_level4", 64'(lvl(4)), 64'd1);
        expect_pop(3'd4, 32'hC0);
        expect_pop(3'd1, 32'hB0);
        for (int i = 0; i < 4; i++) expect_pop(3'd0, 32'hA0 + 32'(i));
        drain(6);
        chk("t3_empty_after", 64'(oEmpty), 64'h1F);

        // T4: steady write+pop on one class, pointers wrap twice; full blocks without look-ahead
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h8, 32'hF00 + 32'(i), 1'b0);
        for (int i = 0; i < 16; i++) expect_pop(3'd4, 32'hF00 + 32'(i));
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 4'h8, 32'hF03 + 32'(k), 1'b1);
            chk("t4_level4_steady", 64'(lvl(4)), 64'd3);
        end
        cyc(1'b1, 4'h8, 32'hF13, 1'b0);
        chk("t4_level4_full", 64'(lvl(4)), 64'd4);
        chk_ready("t4_ready_q8_full", 4'h8, 1'b0);
        chk_ready("t4_ready_q0", 4'h0, 1'b1);
        expect_pop(3'd4, 32'hF10);
        cyc(1'b1, 4'h8, 32'hDEAD, 1'b1);
        chk("t4_level4_popfull", 64'(lvl(4)), 64'd3);
        chk_ready("t4_ready_q8_after", 4'h8, 1'b1);
        for (int i = 0; i < 3; i++) expect_pop(3'd4, 32'hF11 + 32'(i));
        drain(3);
        chk("t4_valid_after", 64'(oRdValid), 64'h0);

        // T5: asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 4'h0, 32'hA0 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'h2, 32'hB0 + 32'(i), 1'b0);
        chk("t5_level1", 64'(lvl(1)), 64'd3);
        #2;
        iResetn = 1'b0;
        #1;
        chk("t5_async_empty", 64'(oEmpty), 64'h1F);
        chk("t5_async_valid", 64'(oRdValid), 64'h0);
        chk("t5_async_ready", 64'(oWrReady), 64'h0);
        chk("t5_async_level", 64'(oLevel), 64'h0);
        @(negedge iClk);
        iResetn = 1'b1;
        @(posedge iClk);
        #1;
        cyc(1'b1, 4'h2, 32'h55, 1'b0);
        chk("t5_level0", 64'(lvl(0)), 64'd1);
        chk("t5_level1_after", 64'(lvl(1)), 64'd0);
        expect_pop(3'd0, 32'h55);
        drain(1);

        // T6: class 0 waits while class 4 is kept busy
        do_reset();
        cyc(1'b1, 4'h0, 32'h60, 1'b0);
        cyc(1'b1, 4'h8, 32'h100, 1'b0);
`ifdef QOS_AGING_EN
        for (int i = 0; i < 3; i++) expect_pop(3'd4, 32'h100 + 32'(i));
        expect_pop(3'd0, 32'h60);
        for (int i = 3; i < 7; i++) expect_pop(3'd4, 32'h100 + 32'(i));
`else
        for (int i = 0; i < 8; i++) expect_pop(3'd4, 32'h100 + 32'(i));
`endif
        for (int k = 1; k <= 8; k++) cyc(1'b1, 4'h8, 32'h100 + 32'(k), 1'b1);
`ifdef QOS_AGING_EN
        chk("t6_level0", 64'(lvl(0)), 64'd0);
        expect_pop(3'd4, 32'h107);
        expect_pop(3'd4, 32'h108);
`else
        chk("t6_level0", 64'(lvl(0)), 64'd1);
        expect_pop(3'd4, 32'h108);
        expect_pop(3'd0, 32'h60);
`endif
        drain(2);
        chk("t6_valid_after", 64'(oRdValid), 64'h0);

        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
